// File: rtl/evg_event_request_arbiter_if.sv
// rtl/evg_event_request_arbiter_if.sv - request and event stream bundle for the EVG event request arbiter
interface evg_event_request_arbiter_if #(
    parameter int EVENTCODE_WIDTH = 8,
    parameter int NUM_INPUTS      = 4
);
    localparam int SOURCE_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS*EVENTCODE_WIDTH-1:0] reqTDATA;
    logic [NUM_INPUTS-1:0]                 reqTVALID;
    logic [NUM_INPUTS-1:0]                 reqTREADY;
    logic [EVENTCODE_WIDTH-1:0]            evgEventTDATA;
    logic                                  evgEventTVALID;
    logic                                  evgEventTREADY;
    logic [SOURCE_WIDTH-1:0]               evgEventSource;

    // Arbiter side: consumes request streams, produces the event stream
    modport slave (
        input  reqTDATA,
        input  reqTVALID,
        output reqTREADY,
        output evgEventTDATA,
        output evgEventTVALID,
        input  evgEventTREADY,
        output evgEventSource
    );

    // Environment side: request producers plus the event transmitter
    modport master (
        output reqTDATA,
        output reqTVALID,
        input  reqTREADY,
        input  evgEventTDATA,
        input  evgEventTVALID,
        output evgEventTREADY,
        input  evgEventSource
    );
endinterface

// File: rtl/evg_event_request_arbiter.sv
// rtl/evg_event_request_arbiter.sv - merges event-request streams into one registered event-code stream
module evg_event_request_arbiter #(
    parameter int EVENTCODE_WIDTH = 8,
    parameter int NUM_INPUTS      = 4,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                                evgTxClk,
    input  logic                                evgTxRst_n,
    input  logic                                fixedPriority,
    evg_event_request_arbiter_if.slave          bus,
    output logic [NUM_INPUTS*COUNTER_WIDTH-1:0] acceptCount,
    output logic [COUNTER_WIDTH-1:0]            nullCount
);
    localparam int SRC_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [SRC_W-1:0]   LAST_INDEX = SRC_W'(NUM_INPUTS - 1);
    localparam logic [SRC_W:0]     NUM_WIDE   = (SRC_W+1)'(NUM_INPUTS);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [SRC_W-1:0]           last_grant_q, last_grant_d;
    logic                       ev_valid_q, ev_valid_d;
    logic [EVENTCODE_WIDTH-1:0] ev_data_q, ev_data_d;
    logic [SRC_W-1:0]           ev_src_q, ev_src_d;
    logic [COUNTER_WIDTH-1:0]   null_cnt_q, null_cnt_d;
    logic [COUNTER_WIDTH-1:0]   accept_cnt_q [NUM_INPUTS];
    logic [COUNTER_WIDTH-1:0]   accept_cnt_d [NUM_INPUTS];

    logic [SRC_W-1:0]           winner;
    logic                       found;
    logic                       slot_free;
    logic                       accept;
    logic                       code_is_null;
    logic [EVENTCODE_WIDTH-1:0] win_code;
    logic [SRC_W:0]             rr_sum;
    logic [SRC_W-1:0]           rr_idx;

    // Pick the winner: lowest index in fixed mode, first valid input after lastGrant otherwise.
    // Loops run from the far end so the last assignment is the highest-precedence candidate.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_sum = '0;
        rr_idx = '0;
        if (fixedPriority) begin
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (bus.reqTVALID[i]) begin
                    winner = SRC_W'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_INPUTS; k >= 1; k--) begin
                rr_sum = {1'b0, last_grant_q} + (SRC_W+1)'(k);
                if (rr_sum >= NUM_WIDE) begin
                    rr_sum = rr_sum - NUM_WIDE;
                end
                rr_idx = rr_sum[SRC_W-1:0];
                if (bus.reqTVALID[rr_idx]) begin
                    winner = rr_idx;
                    found  = 1'b1;
                end
            end
        end
    end

    // Grant only when the output slot can take a new event this cycle
    always_comb begin
        slot_free     = !ev_valid_q || bus.evgEventTREADY;
        accept        = found && slot_free;
        win_code      = '0;
        bus.reqTREADY = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (winner == SRC_W'(i)) begin
                win_code         = bus.reqTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
                bus.reqTREADY[i] = accept;
            end
        end
        code_is_null = (win_code == '0);
    end

    // Next state of the output slot, round-robin pointer and saturating counters
    always_comb begin
        ev_valid_d   = ev_valid_q;
        ev_data_d    = ev_data_q;
        ev_src_d     = ev_src_q;
        last_grant_d = last_grant_q;
        null_cnt_d   = null_cnt_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            accept_cnt_d[i] = accept_cnt_q[i];
        end

        if (bus.evgEventTREADY) begin
            ev_valid_d = 1'b0;
        end

        if (accept) begin
            // Null codes still move the pointer so a stream of zeros cannot hog the grant
            last_grant_d = winner;
            if (code_is_null) begin
                if (null_cnt_q != CNT_MAX) begin
                    null_cnt_d = null_cnt_q + 1'b1;
                end
            end else begin
                ev_valid_d = 1'b1;
                ev_data_d  = win_code;
                ev_src_d   = winner;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (winner == SRC_W'(i) && accept_cnt_q[i] != CNT_MAX) begin
                        accept_cnt_d[i] = accept_cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // State registers; a reset drops any pending event and clears all status
    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            ev_valid_q   <= 1'b0;
            ev_data_q    <= '0;
            ev_src_q     <= '0;
            last_grant_q <= LAST_INDEX;
            null_cnt_q   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                accept_cnt_q[i] <= '0;
            end
        end else begin
            ev_valid_q   <= ev_valid_d;
            ev_data_q    <= ev_data_d;
            ev_src_q     <= ev_src_d;
            last_grant_q <= last_grant_d;
            null_cnt_q   <= null_cnt_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                accept_cnt_q[i] <= accept_cnt_d[i];
            end
        end
    end

    assign bus.evgEventTVALID = ev_valid_q;
    assign bus.evgEventTDATA  = ev_data_q;
    assign bus.evgEventSource = ev_src_q;
    assign nullCount          = null_cnt_q;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_count_out
        assign acceptCount[g*COUNTER_WIDTH +: COUNTER_WIDTH] = accept_cnt_q[g];
    end
endmodule

// File: tb/tb_evg_event_request_arbiter.sv
// tb/tb_evg_event_request_arbiter.sv - scoreboard bench for the EVG event request arbiter
module tb_evg_event_request_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          fixed_prio;
    logic [N*CW-1:0] accept_count;
    logic [CW-1:0] null_count;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb [$];

    evg_event_request_arbiter_if #(.EVENTCODE_WIDTH(W), .NUM_INPUTS(N)) bus_if ();

    evg_event_request_arbiter #(
        .EVENTCODE_WIDTH(W),
        .NUM_INPUTS(N),
        .COUNTER_WIDTH(CW)
    ) dut (
        .evgTxClk(clk),
        .evgTxRst_n(rst_n),
        .fixedPriority(fixed_prio),
        .bus(bus_if),
        .acceptCount(accept_count),
        .nullCount(null_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] code, input logic [1:0] src);
        sb.push_back({src, code});
    endtask

    function automatic logic [31:0] acc(input int i);
        return 32'(accept_count[i*CW +: CW]);
    endfunction

    task automatic set_code(input int i, input logic [7:0] code);
        bus_if.reqTDATA[i*W +: W] = code;
    endtask

    // Monitor: every event the transmitter takes must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && bus_if.evgEventTVALID && bus_if.evgEventTREADY) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %0h src %0d expected none",
                         bus_if.evgEventTDATA, bus_if.evgEventSource);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                if ({bus_if.evgEventSource, bus_if.evgEventTDATA} !== e) begin
                    errors++;
                    $display("FAIL event: got %0h src %0d expected %0h src %0d",
                             bus_if.evgEventTDATA, bus_if.evgEventSource, e[7:0], e[9:8]);
                end
            end
        end
    end

    logic [3:0] rr_rdy  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_code [8] = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [1:0] rr_src  [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst_n                 = 1'b0;
        fixed_prio            = 1'b0;
        bus_if.reqTDATA       = '0;
        bus_if.reqTVALID      = '0;
        bus_if.evgEventTREADY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", bus_if.evgEventTVALID, 0);
        check("reset_tdata", bus_if.evgEventTDATA, 0);
        check("reset_source", bus_if.evgEventSource, 0);
        check("reset_counts", accept_count, 0);
        check("reset_null", null_count, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single request from input 0
        set_code(0, 8'h7A);
        bus_if.reqTVALID = 4'b0001;
        push_exp(8'h7A, 2'd0);
        @(negedge clk);
        check("single_ready", bus_if.reqTREADY, 4'b0001);
        step();
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("single_ready_drop", bus_if.reqTREADY, 0);
        check("single_acc0", acc(0), 1);
        step();

        // Round-robin with all inputs valid; pointer sits at 0 after the previous grant
        for (int i = 0; i < N; i++) set_code(i, 8'h10 + 8'(i));
        bus_if.reqTVALID = 4'b1111;
        for (int k = 0; k < 8; k++) push_exp(rr_code[k], rr_src[k]);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_ready", bus_if.reqTREADY, rr_rdy[k]);
            step();
        end
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("rr_acc0", acc(0), 3);
        check("rr_acc1", acc(1), 2);
        check("rr_acc2", acc(2), 2);
        check("rr_acc3", acc(3), 2);
        step();

        // Fixed priority: input 1 starves input 3 until it drops
        fixed_prio = 1'b1;
        set_code(1, 8'h21);
        set_code(3, 8'h23);
        bus_if.reqTVALID = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            push_exp(8'h21, 2'd1);
            @(negedge clk);
            check("fixed_ready_in1", bus_if.reqTREADY, 4'b0010);
            step();
        end
        bus_if.reqTVALID = 4'b1000;
        push_exp(8'h23, 2'd3);
        @(negedge clk);
        check("fixed_ready_in3", bus_if.reqTREADY, 4'b1000);
        step();
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("fixed_acc1", acc(1), 6);
        check("fixed_acc3", acc(3), 3);
        step();

        // Backpressure with 0x22 held in the slot and input 2 waiting
        fixed_prio = 1'b0;
        set_code(2, 8'h22);
        bus_if.reqTVALID = 4'b0100;
        push_exp(8'h22, 2'd2);
        @(negedge clk);
        check("bp_first_ready", bus_if.reqTREADY, 4'b0100);
        step();
        set_code(2, 8'h2B);
        bus_if.evgEventTREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready_low", bus_if.reqTREADY, 0);
            check("bp_hold_data", bus_if.evgEventTDATA, 8'h22);
            check("bp_hold_src", bus_if.evgEventSource, 2);
            check("bp_hold_valid", bus_if.evgEventTVALID, 1);
            step();
        end
        bus_if.evgEventTREADY = 1'b1;
        push_exp(8'h2B, 2'd2);
        @(negedge clk);
        check("bp_release_ready", bus_if.reqTREADY, 4'b0100);
        step();
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("bp_valid_continuous", bus_if.evgEventTVALID, 1);
        step();
        @(negedge clk);
        check("bp_drained", bus_if.evgEventTVALID, 0);
        step();

        // Null code is consumed but never reaches the output
        set_code(0, 8'h00);
        bus_if.reqTVALID = 4'b0001;
        @(negedge clk);
        check("null_ready", bus_if.reqTREADY, 4'b0001);
        step();
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("null_no_valid", bus_if.evgEventTVALID, 0);
        check("null_count", null_count, 1);
        check("null_acc0", acc(0), 3);
        step();

        // Saturation: 20 events from input 1; the last one is left in the slot
        bus_if.reqTVALID = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            set_code(1, 8'h40 + 8'(k));
            if (k < 19) push_exp(8'h40 + 8'(k), 2'd1);
            @(negedge clk);
            check("sat_ready", bus_if.reqTREADY, 4'b0010);
            step();
        end
        bus_if.evgEventTREADY = 1'b0;
        set_code(1, 8'h60);
        @(negedge clk);
        check("sat_acc1", acc(1), 15);
        check("sat_slot_data", bus_if.evgEventTDATA, 8'h53);
        check("sat_stall_ready", bus_if.reqTREADY, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", bus_if.evgEventTVALID, 0);
        check("rst_tdata", bus_if.evgEventTDATA, 0);
        check("rst_counts", accept_count, 0);
        check("rst_null", null_count, 0);
        step();
        step();
        rst_n = 1'b1;
        bus_if.evgEventTREADY = 1'b1;
        push_exp(8'h60, 2'd1);
        @(negedge clk);
        check("post_rst_ready", bus_if.reqTREADY, 4'b0010);
        step();
        bus_if.reqTVALID = 4'b0000;
        @(negedge clk);
        check("post_rst_acc1", acc(1), 1);
        step();
        step();
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/evg_event_request_arbiter.md
Name: evg_event_request_arbiter

Overview:
- Merges several event-request streams (software trigger, hardware trigger inputs, sequencer) into the single event-code stream consumed by the EVG event transmitter.
- Sits directly downstream of the software-trigger request stage in the evgTxClk domain; one of its inputs is that stage's TDATA/TVALID/TREADY stream.
- Provides round-robin or fixed-priority arbitration, one registered output slot, discard of null codes, and per-input saturating accept counters for status readout.

Parameters:
- EVENTCODE_WIDTH, 8, width of an event code.
- NUM_INPUTS, 4, number of request streams (2..8).
- COUNTER_WIDTH, 16, width of each per-input accept counter and the null-discard counter.

Ports:
- evgTxClk  input  1  event transmitter clock; only clock.
- evgTxRst_n  input  1  asynchronous active-low reset.
- fixedPriority  input  1  1 = input 0 highest priority; 0 = round-robin.
- reqTDATA  input  NUM_INPUTS*EVENTCODE_WIDTH  request codes; input i occupies bits [i*W +: W].
- reqTVALID  input  NUM_INPUTS  request valid per input.
- reqTREADY  output  NUM_INPUTS  request accepted per input; one-hot or zero.
- evgEventTDATA  output  EVENTCODE_WIDTH  event code to transmitter.
- evgEventTVALID  output  1  output slot holds an event.
- evgEventTREADY  input  1  transmitter takes the event.
- evgEventSource  output  clog2(NUM_INPUTS)  index of the input that supplied evgEventTDATA.
- acceptCount  output  NUM_INPUTS*COUNTER_WIDTH  per-input accepted-request counters.
- nullCount  output  COUNTER_WIDTH  count of zero-code requests discarded.

Behaviour:
- Reset: async assert on evgTxRst_n low. evgEventTVALID=0, evgEventTDATA=0, evgEventSource=0, all counters 0. Round-robin pointer lastGrant=NUM_INPUTS-1, so input 0 wins first. Deassertion is sampled synchronously.
- Slot free: `slotFree = !evgEventTVALID || evgEventTREADY`.
- Arbitration is combinational each cycle.
  - Candidates are inputs with reqTVALID=1.
  - fixedPriority=1: lowest-index candidate wins.
  - fixedPriority=0: first candidate after lastGrant, searching upward with wrap-around.
- Grant: reqTREADY[winner]=1 only if slotFree and a candidate exists. All other bits are 0.
- Handshake: a request is accepted on a cycle with reqTVALID[i] && reqTREADY[i].
- Accepted code != 0:
  - Next cycle evgEventTVALID=1, evgEventTDATA=code, evgEventSource=i.
  - Latency is 1 clock from accept to output valid.
- Accepted code == 0: the request is consumed and discarded. No output slot is loaded and nullCount increments.
- Slot drained with no new load: evgEventTVALID falls to 0 on the next clock.
- Drain and load in the same cycle: the new event replaces the old one with evgEventTVALID held at 1. Full throughput is one event per clock.
- lastGrant updates to the winner on every accept, including null codes and including fixedPriority mode. Switching modes therefore needs no reset.
- Output stability: while evgEventTVALID=1 and evgEventTREADY=0, evgEventTDATA and evgEventSource are held constant and no reqTREADY asserts.
- acceptCount[i] increments on every accepted non-null request from input i. All counters saturate at all-ones and never wrap.
- Inputs must keep reqTVALID/reqTDATA stable until accepted. The block does not check this.
- Reset mid-operation: any pending output event is lost and counters clear. Upstream requests stay pending and are granted after reset release.
- No combinational path from reqTVALID to evgEventTVALID. reqTREADY depends combinationally on reqTVALID, evgEventTVALID and evgEventTREADY.

Test Plan:
- Reset, then reqTVALID=0001 with code 0x7A and evgEventTREADY=1.
  - reqTREADY=0001 for one cycle.
  - Next cycle evgEventTVALID=1, TDATA=0x7A, Source=0.
  - acceptCount[0]=1.
- Round-robin: all 4 inputs valid continuously with codes 0x10..0x13, fixedPriority=0, TREADY=1.
  - Output sequence is 0x10,0x11,0x12,0x13,0x10,… one per clock.
  - Each acceptCount advances equally.
- Fixed priority: inputs 1 and 3 valid, fixedPriority=1.
  - Input 1 is granted every cycle and input 3 is starved.
  - After input 1 drops, input 3 is granted on the next free slot.
- Backpressure: TREADY=0 for 5 cycles with 0x22 in the slot and input 2 valid.
  - Output holds 0x22 and reqTREADY=0 throughout.
  - On TREADY=1 the same-cycle replacement occurs with TVALID continuous.
- Null code: input 0 presents 0x00.
  - Accepted, no output valid, nullCount=1, acceptCount[0] unchanged.
- Saturation and reset: with COUNTER_WIDTH=4, send 20 events from input 1.
  - acceptCount[1]=15.
  - Assert evgTxRst_n=0 mid-stream: TVALID=0 immediately and all counters 0.
